// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point multiplier:
// FSM state encoding, default field widths and canonical special-value fields.
package fp_pkg;

    // Default IEEE single-precision layout
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    // Controller states: accept, iterate significands, normalise, pack/round
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_NORM = 2'd2,
        ST_PACK = 2'd3
    } fp_state_t;

    // Canonical quiet NaN is positive with only the fraction MSB set;
    // infinity uses the all-ones exponent with an all-zero fraction.
    localparam logic                QNAN_SIGN     = 1'b0;
    localparam logic [FP_EXP_W-1:0] SPECIAL_EXP   = '1;
    localparam logic [FP_MAN_W-1:0] DEF_QNAN_FRAC = {1'b1, {(FP_MAN_W-1){1'b0}}};
    localparam logic [FP_MAN_W-1:0] DEF_INF_FRAC  = '0;

endpackage

// File: rtl/fp_mant_mul.sv
// Iterative shift-add significand multiplier: one multiplier bit per clock,
// exactly SIG_W iterations after the start cycle, then a one-cycle done pulse.
module fp_mant_mul
    import fp_pkg::*;
#(
    parameter int SIG_W = FP_MAN_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SIG_W-1:0]     mcand,
    input  logic [SIG_W-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*SIG_W-1:0]   product
);

    localparam int               CNT_W    = $clog2(SIG_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIG_W - 1);

    logic [2*SIG_W-1:0] mcand_reg;
    logic [SIG_W-1:0]   mplier_reg;
    logic [2*SIG_W-1:0] prod_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [2*SIG_W-1:0] addend;

    // Partial product for this step: the shifted multiplicand gated by the
    // current multiplier LSB
    generate
        for (genvar gi = 0; gi < 2*SIG_W; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    // Load operands on start, then accumulate one bit per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (!busy_reg && start) begin
                mcand_reg  <= {{SIG_W{1'b0}}, mcand};
                mplier_reg <= mplier;
                prod_reg   <= '0;
                cnt_reg    <= '0;
                busy_reg   <= 1'b1;
            end else if (busy_reg) begin
                prod_reg   <= prod_reg + addend;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = prod_reg;

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential floating-point multiplier: IDLE -> MULT -> NORM -> PACK -> IDLE.
// Result appears MAN_W+4 clocks after the accepting edge, special cases included.
// Build option: define FP_MUL_ROUND_EN for round-to-nearest-even in PACK;
// without it PACK truncates toward zero.
module fp_mul_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mul_start,
    input  logic [EXP_W+MAN_W:0]     op1,
    input  logic [EXP_W+MAN_W:0]     op2,
    output logic                     mul_busy,
    output logic                     mul_done,
    output logic [EXP_W+MAN_W:0]     mul_result,
    output logic                     mul_overflow,
    output logic                     mul_underflow
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int XW     = EXP_W + 2;

    localparam logic [XW-1:0]    BIAS_X    = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [MAN_W-1:0] QNAN_FRAC = {1'b1, {(MAN_W-1){1'b0}}};

    fp_state_t state_reg, state_next;

    logic [W-1:0]        op_reg [2];
    logic [PROD_W-1:0]   prod_reg;
    logic [2*MAN_W-1:0]  norm_reg;     // fraction bits below the hidden one
    logic [XW-1:0]       exp_reg;
    logic [W-1:0]        mul_result_reg;
    logic                mul_done_reg;
    logic                mul_overflow_reg;
    logic                mul_underflow_reg;

    logic                mant_start;
    logic                mant_busy;
    logic                mant_done;
    logic [PROD_W-1:0]   mant_product;

    // Per-operand field decode of the latched operands
    logic [1:0]          sgn_f;
    logic [EXP_W-1:0]    ex_f   [2];
    logic [1:0]          is_zero;
    logic [1:0]          is_inf;
    logic [1:0]          is_nan;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_field
            assign sgn_f[gi]   = op_reg[gi][W-1];
            assign ex_f[gi]    = op_reg[gi][W-2:MAN_W];
            assign is_zero[gi] = (ex_f[gi] == '0);
            assign is_inf[gi]  = (ex_f[gi] == EXP_ONES) && (op_reg[gi][MAN_W-1:0] == '0);
            assign is_nan[gi]  = (ex_f[gi] == EXP_ONES) && (op_reg[gi][MAN_W-1:0] != '0);
        end
    endgenerate

    // The significand unit latches the raw inputs on the same edge that the
    // controller accepts the request, so its count starts with MULT.
    assign mant_start = (state_reg == ST_IDLE) && mul_start;

    fp_mant_mul #(
        .SIG_W (SIG_W)
    ) u_mant_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mant_start),
        .mcand   ({(op1[W-2:MAN_W] != '0), op1[MAN_W-1:0]}),
        .mplier  ({(op2[W-2:MAN_W] != '0), op2[MAN_W-1:0]}),
        .busy    (mant_busy),
        .done    (mant_done),
        .product (mant_product)
    );

    // Biased exponent of the unnormalised product; two guard bits keep the sign
    logic [XW-1:0] exp_sum;
    assign exp_sum = {2'b00, ex_f[0]} + {2'b00, ex_f[1]} - BIAS_X;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (mul_start)              state_next = ST_MULT;
            ST_MULT: if (mant_done && !mant_busy) state_next = ST_NORM;
            ST_NORM:                              state_next = ST_PACK;
            ST_PACK:                              state_next = ST_IDLE;
            default:                              state_next = ST_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        mul_busy = (state_reg != ST_IDLE);
    end

    // Round or truncate the normalised fraction into the final field values
    logic [MAN_W-1:0]        frac_t;
    logic [MAN_W-1:0]        frac_r;
    logic signed [XW-1:0]    exp_fin;
    assign frac_t = norm_reg[2*MAN_W-1:MAN_W];

`ifdef FP_MUL_ROUND_EN
    logic guard_bit;
    logic sticky_bit;
    logic round_up;
    logic mant_carry;
    assign guard_bit  = norm_reg[MAN_W-1];
    assign sticky_bit = |norm_reg[MAN_W-2:0];
    assign round_up   = guard_bit & (sticky_bit | frac_t[0]);
    assign {mant_carry, frac_r} = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
    // A carry out of the fraction means 1.11..1 rounded up to 10.0: the
    // fraction is already zero, only the exponent moves.
    assign exp_fin = $signed(exp_reg + {{(XW-1){1'b0}}, mant_carry});
`else
    assign frac_r  = frac_t;
    assign exp_fin = $signed(exp_reg);
`endif

    // Special-case priority and exponent range check for the packed word
    logic [W-1:0] pack_result;
    logic         pack_ovf;
    logic         pack_unf;
    logic         res_sign;
    always_comb begin
        res_sign    = sgn_f[0] ^ sgn_f[1];
        pack_result = '0;
        pack_ovf    = 1'b0;
        pack_unf    = 1'b0;
        if ((|is_nan) || (is_inf[0] && is_zero[1]) || (is_inf[1] && is_zero[0])) begin
            pack_result = {QNAN_SIGN, EXP_ONES, QNAN_FRAC};
        end else if (|is_inf) begin
            pack_result = {res_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (|is_zero) begin
            pack_result = {res_sign, {(W-1){1'b0}}};
        end else if (exp_fin >= $signed({2'b00, EXP_ONES})) begin
            pack_result = {res_sign, EXP_ONES, {MAN_W{1'b0}}};
            pack_ovf    = 1'b1;
        end else if (exp_fin <= $signed({XW{1'b0}})) begin
            pack_result = {res_sign, {(W-1){1'b0}}};
            pack_unf    = 1'b1;
        end else begin
            pack_result = {res_sign, exp_fin[EXP_W-1:0], frac_r};
        end
    end

    // Datapath: latch operands, capture product, normalise, publish result
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg[0]         <= '0;
            op_reg[1]         <= '0;
            prod_reg          <= '0;
            norm_reg          <= '0;
            exp_reg           <= '0;
            mul_result_reg    <= '0;
            mul_done_reg      <= 1'b0;
            mul_overflow_reg  <= 1'b0;
            mul_underflow_reg <= 1'b0;
        end else begin
            mul_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (mul_start) begin
                        op_reg[0] <= op1;
                        op_reg[1] <= op2;
                    end
                end
                ST_MULT: begin
                    if (mant_done) begin
                        prod_reg <= mant_product;
                    end
                end
                ST_NORM: begin
                    // Product lies in [1,4); a set MSB means [2,4). The bit
                    // shifted out is folded into the sticky position.
                    if (prod_reg[PROD_W-1]) begin
                        norm_reg <= {prod_reg[PROD_W-2:2], prod_reg[1] | prod_reg[0]};
                        exp_reg  <= exp_sum + {{(XW-1){1'b0}}, 1'b1};
                    end else begin
                        norm_reg <= prod_reg[2*MAN_W-1:0];
                        exp_reg  <= exp_sum;
                    end
                end
                ST_PACK: begin
                    mul_result_reg    <= pack_result;
                    mul_overflow_reg  <= pack_ovf;
                    mul_underflow_reg <= pack_unf;
                    mul_done_reg      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mul_done      = mul_done_reg;
    assign mul_result    = mul_result_reg;
    assign mul_overflow  = mul_overflow_reg;
    assign mul_underflow = mul_underflow_reg;

endmodule
